// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: masked set/reset pulse driver for an SR flop bank; SR_READBACK_EN adds q_in readback checking
module sr_pulse_driver #(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_mask,
    input  logic [WIDTH-1:0] req_value,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
`ifdef SR_READBACK_EN
    input  logic [WIDTH-1:0] q_in,
    output logic             rb_err,
    output logic [WIDTH-1:0] rb_err_bits,
    output logic [WIDTH-1:0] shadow
`else
    output logic [WIDTH-1:0] shadow
`endif
);
    localparam int MX = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW = MX > 0 ? $clog2(MX + 1) : 1;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] s_n, r_n, shadow_n, mask_q, mask_n, value_q, value_n, set_v, clr_v;
    logic done_n;

    assign req_ready = state == IDLE;
    assign busy = !req_ready;
    assign set_v = req_mask & req_value & ~shadow;
    assign clr_v = req_mask & ~req_value & shadow;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            s <= '0;
            r <= '0;
            shadow <= '0;
            done <= 1'b0;
            mask_q <= '0;
            value_q <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            s <= s_n;
            r <= r_n;
            shadow <= shadow_n;
            done <= done_n;
            mask_q <= mask_n;
            value_q <= value_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        s_n = s;
        r_n = r;
        shadow_n = shadow;
        done_n = 1'b0;
        mask_n = mask_q;
        value_n = value_q;
        case (state)
            IDLE: if (req_valid) begin
                mask_n = req_mask;
                value_n = req_value;
                s_n = set_v;
                r_n = clr_v;
                if (|(set_v | clr_v)) begin
                    state_n = PULSE;
                    cnt_n = CW'(PULSE_CYCLES - 1);
                end else begin
                    done_n = 1'b1;
                end
            end
            PULSE: if (cnt == '0) begin
                s_n = '0;
                r_n = '0;
                shadow_n = (shadow & ~mask_q) | (value_q & mask_q);
                if (GAP_CYCLES > 0) begin
                    state_n = GAP;
                    cnt_n = CW'(GAP_CYCLES - 1);
                end else begin
                    state_n = IDLE;
                    done_n = 1'b1;
                end
            end else begin
                cnt_n = cnt - 1'b1;
            end
            GAP: if (cnt == '0) begin
                state_n = IDLE;
                done_n = 1'b1;
            end else begin
                cnt_n = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef SR_READBACK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rb_err <= 1'b0;
            rb_err_bits <= '0;
        end else if (done) begin
            rb_err <= rb_err | (|((q_in ^ shadow) & mask_q));
            rb_err_bits <= rb_err_bits | ((q_in ^ shadow) & mask_q);
        end
    end
`else
`endif
endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: directed self-checking bench for sr_pulse_driver (WIDTH=8, PULSE=2, GAP=1)
module tb_sr_pulse_driver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [7:0] req_mask = '0;
    logic [7:0] req_value = '0;
    logic [7:0] s, r, shadow;
    logic busy, done;
    int checks = 0;
    int errors = 0;
`ifdef SR_READBACK_EN
    logic [7:0] q_in = '0;
    logic rb_err;
    logic [7:0] rb_err_bits;
`endif

    sr_pulse_driver #(.WIDTH(8), .PULSE_CYCLES(2), .GAP_CYCLES(1)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_mask(req_mask),
        .req_value(req_value),
        .s(s),
        .r(r),
        .busy(busy),
        .done(done),
`ifdef SR_READBACK_EN
        .q_in(q_in),
        .rb_err(rb_err),
        .rb_err_bits(rb_err_bits),
`endif
        .shadow(shadow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [7:0] es, input logic [7:0] er, input logic [7:0] esh,
                        input logic erdy, input logic ebusy, input logic edone);
        chk({tag, ".s"}, 32'(s), 32'(es));
        chk({tag, ".r"}, 32'(r), 32'(er));
        chk({tag, ".s&r"}, 32'(s & r), 32'h0);
        chk({tag, ".shadow"}, 32'(shadow), 32'(esh));
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(erdy));
        chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
        chk({tag, ".done"}, 32'(done), 32'(edone));
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        outs("t1_idle", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

        req_valid = 1'b1; req_mask = 8'hFF; req_value = 8'hA5;
        @(negedge clock);
        outs("t2_c1", 8'hA5, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        req_mask = 8'h3C; req_value = 8'h00;
        @(negedge clock);
        outs("t2_c2", 8'hA5, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        outs("t2_gap", 8'h00, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0);
        req_valid = 1'b0;
        @(negedge clock);
        outs("t2_done", 8'h00, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b1);

        req_valid = 1'b1; req_mask = 8'h0F; req_value = 8'h0A;
        @(negedge clock);
        req_valid = 1'b0;
        outs("t3_c1", 8'h0A, 8'h05, 8'hA5, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        outs("t3_c2", 8'h0A, 8'h05, 8'hA5, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        outs("t3_gap", 8'h00, 8'h00, 8'hAA, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        outs("t3_done", 8'h00, 8'h00, 8'hAA, 1'b1, 1'b0, 1'b1);

        req_valid = 1'b1; req_mask = 8'hF0; req_value = 8'hA0;
        @(negedge clock);
        outs("t4_noop", 8'h00, 8'h00, 8'hAA, 1'b1, 1'b0, 1'b1);
        req_mask = 8'h01; req_value = 8'h01;
        @(negedge clock);
        req_valid = 1'b0;
        outs("t4_b2b_c1", 8'h01, 8'h00, 8'hAA, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        outs("t4_b2b_gap", 8'h00, 8'h00, 8'hAB, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        outs("t4_b2b_done", 8'h00, 8'h00, 8'hAB, 1'b1, 1'b0, 1'b1);

        req_valid = 1'b1; req_mask = 8'hF0; req_value = 8'h00;
        @(negedge clock);
        req_valid = 1'b0;
        outs("t5_c1", 8'h00, 8'hA0, 8'hAB, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        outs("t5_rst", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        outs("t5_after", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        outs("t5_after2", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

`ifdef SR_READBACK_EN
        chk("t6_rb_clear", 32'(rb_err), 32'h0);
        req_valid = 1'b1; req_mask = 8'h01; req_value = 8'h01;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("t6_done", 32'(done), 32'h1);
        chk("t6_rb_pre", 32'(rb_err), 32'h0);
        @(negedge clock);
        chk("t6_rb_err", 32'(rb_err), 32'h1);
        chk("t6_rb_bits", 32'(rb_err_bits), 32'h01);
        repeat (3) @(negedge clock);
        chk("t6_rb_sticky", 32'(rb_err), 32'h1);
        chk("t6_rb_bits_sticky", 32'(rb_err_bits), 32'h01);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_rb_rst", 32'(rb_err), 32'h0);
        chk("t6_rb_bits_rst", 32'(rb_err_bits), 32'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sr_pulse_driver.md
Name: sr_pulse_driver

Overview:
Command-side driver for a bank of WIDTH SR flip-flops. It accepts masked target-level requests over a valid/ready handshake and converts them into timed set/reset pulses on s/r. By construction it never drives s=r=1 on any bit. It keeps a shadow copy of the expected flop state, so it pulses only the bits that actually change. It sits between control logic and the SR storage bank, which resets to q=0.

Parameters:
WIDTH, 8, number of SR channels driven.
PULSE_CYCLES, 2, cycles s/r are held high per pulse; legal range >=1.
GAP_CYCLES, 1, guard cycles with s=r=0 after a pulse before the next request is accepted; legal range >=0.

Ports:
clock  input  1  clock; all state updates on its rising edge.
reset  input  1  reset, synchronous, active-high; clock clock.
req_valid  input  1  request present.
req_ready  output  1  high when state==IDLE (combinational from state).
req_mask  input  WIDTH  channels addressed by the request.
req_value  input  WIDTH  target level per addressed channel.
s  output  WIDTH  set pulses to the flop bank (registered).
r  output  WIDTH  reset pulses to the flop bank (registered).
busy  output  1  state!=IDLE.
done  output  1  one-cycle completion strobe (registered).
shadow  output  WIDTH  expected flop-bank state (registered).

Behaviour:
- Reset values: s=0, r=0, shadow=0, done=0, state=IDLE, counter=0. Consequences: req_ready=1 and busy=0 from the first cycle after reset. Requests presented during a reset cycle are ignored.
- States: IDLE, PULSE, GAP.
- Accept: occurs on an edge where req_valid && req_ready && !reset. At accept, capture:
  - mask_q = req_mask, value_q = req_value
  - set_v = req_mask & req_value & ~shadow
  - clr_v = req_mask & ~req_value & shadow
- set_v & clr_v == 0 always, so no bit ever sees s=r=1.
- No-op request (set_v==0 and clr_v==0):
  - Stay in IDLE; s/r stay 0; shadow is unchanged.
  - done=1 in the cycle after accept. Back-to-back acceptance is permitted.
- Active request: on the accept edge, s=set_v, r=clr_v, state=PULSE, counter=PULSE_CYCLES-1.
- PULSE:
  - Hold s/r constant; decrement counter each edge.
  - At counter==0 edge:
    - s=0, r=0
    - shadow = (shadow & ~mask_q) | (value_q & mask_q)
    - If GAP_CYCLES>0: state=GAP, counter=GAP_CYCLES-1.
    - If GAP_CYCLES==0: state=IDLE, done=1.
- GAP: s=r=0; decrement counter. At counter==0 edge: state=IDLE, done=1.
- Latency (accept edge = edge 0):
  - s/r high in cycles 1..PULSE_CYCLES.
  - Gap in cycles PULSE_CYCLES+1..PULSE_CYCLES+GAP_CYCLES.
  - done=1 and req_ready=1 in cycle PULSE_CYCLES+GAP_CYCLES+1.
- done is high exactly one cycle per accepted request. It is otherwise 0.
- Input hold: req_* may change freely while busy; only the values captured at accept are used.
- Reset mid-operation: on the reset edge, s/r go to 0, shadow goes to 0 and state goes to IDLE. The in-flight request is dropped with no done.
- Counter width: $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1), minimum 1 bit.

Optional Feature:
Macro SR_READBACK_EN.
- When defined:
  - Adds input q_in[WIDTH] (flop bank q outputs).
  - Adds outputs rb_err (1 bit) and rb_err_bits[WIDTH].
  - In every cycle where done=1, the block compares (q_in & mask_q) against (shadow & mask_q).
  - Any differing bits are ORed into rb_err_bits, and rb_err is set, at the next edge.
  - rb_err and rb_err_bits are sticky; only reset clears them to 0.
  - For no-op requests the comparison still occurs, using that request's mask.
- When undefined: q_in, rb_err and rb_err_bits do not exist, no compare logic is built, and all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8, PULSE_CYCLES=2, GAP_CYCLES=1.
1. Reset then idle -> s=r=0x00, shadow=0x00, req_ready=1, busy=0, done=0.
2. Accept mask=0xFF, value=0xA5 from shadow 0x00 -> s=0xA5, r=0x00 for cycles 1-2; gap in cycle 3; done=1 in cycle 4; shadow=0xA5.
3. From shadow 0xA5, accept mask=0x0F, value=0x0A -> s=0x0A, r=0x05 for 2 cycles; (s&r)==0 every cycle; shadow=0xAA.
4. From shadow 0xAA, accept mask=0xF0, value=0xA0 (no-op) -> s=r=0 throughout; done=1 in cycle 1; immediately accept a second request next cycle; shadow stays 0xAA.
5. Reset asserted in the second PULSE cycle of a request -> s=r=0, shadow=0x00, state IDLE after the edge; no done pulse.
6. With SR_READBACK_EN: tie q_in=0x00, accept mask=0x01, value=0x01 -> at done, rb_err=1 and rb_err_bits=0x01; both stay set until reset.
